// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared types, constants and glyph decoder for the seven-segment scanner
// Contents: digit_idx_t, scan_state_t, SEG_OFF/AN_OFF blanking levels, hex2seg (active-low {g,f,e,d,c,b,a}).
package seg7_pkg;

    typedef logic [1:0] digit_idx_t;

    typedef enum logic [1:0] {
        RESET_IDLE = 2'd0,
        BLANK      = 2'd1,
        SHOW       = 2'd2
    } scan_state_t;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [3:0] AN_OFF  = 4'hF;

    function automatic logic [6:0] hex2seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/wrap_tracker.sv
// rtl/wrap_tracker.sv - counts 7->0 wrap-arounds of a 3-bit count, saturating at 15
// Ports: clk_f clock; rst sync active-high reset; cnt[2:0] sampled count;
//        wrap[3:0] registered wrap count; sat high while wrap == 15.
module wrap_tracker (
    input  logic       clk_f,
    input  logic       rst,
    input  logic [2:0] cnt,
    output logic [3:0] wrap,
    output logic       sat
);

    logic [2:0] prev;

    assign sat = (wrap == 4'hF);

    always_ff @(posedge clk_f) begin
        if (rst) begin
            prev <= 3'd0;
            wrap <= 4'd0;
        end else begin
            prev <= cnt;
            if (cnt == 3'd0 && prev == 3'd7) begin
                if (!sat) begin
                    wrap <= wrap + 4'd1;
                end
            end else if (cnt == 3'd0 && prev != 3'd0) begin
                // Dropping to zero from mid-range means the upstream counter was reset.
                wrap <= 4'd0;
            end
        end
    end

endmodule

// File: rtl/seg7_scan.sv
// rtl/seg7_scan.sv - 4-digit common-anode display scanner for slow/fast event counts
// Ports: clk_f clock; rst sync active-high reset; count_s[2:0]/count_f[2:0] upstream counts;
//        an[3:0] active-low anodes; seg[6:0] active-low {g,f,e,d,c,b,a}; dp active-low decimal point.
// Digits: 0 = count_f, 1 = wrap_f, 2 = count_s, 3 = wrap_s.
// Build option: SEG7_SCAN_BLANK_EN inserts BLANK_CYC dark cycles at the start of each slot.
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV = 1000,
    parameter int BLANK_CYC   = 16
) (
    input  logic       clk_f,
    input  logic       rst,
    input  logic [2:0] count_s,
    input  logic [2:0] count_f,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

`ifdef SEG7_SCAN_BLANK_EN
    localparam bit BLANK_EN = 1'b1;
`else
    localparam bit BLANK_EN = 1'b0;
`endif

    localparam logic [15:0] PCNT_MAX  = 16'(REFRESH_DIV - 1);
    localparam logic [15:0] BLANK_LIM = 16'(BLANK_CYC);

    logic [15:0] pcnt;
    digit_idx_t  dig;
    scan_state_t state_q, state_d;

    logic [3:0] wrap_f, wrap_s;
    logic       sat_f, sat_s;

    logic [3:0] sel_val, snap_q, snap_d;
    logic       sel_sat, snap_sat_q, snap_sat_d;
    logic [3:0] an_d;
    logic [6:0] seg_d;
    logic       dp_d;

    wrap_tracker u_wrap_f (
        .clk_f (clk_f),
        .rst   (rst),
        .cnt   (count_f),
        .wrap  (wrap_f),
        .sat   (sat_f)
    );

    wrap_tracker u_wrap_s (
        .clk_f (clk_f),
        .rst   (rst),
        .cnt   (count_s),
        .wrap  (wrap_s),
        .sat   (sat_s)
    );

    always_comb begin
        sel_val = 4'd0;
        sel_sat = 1'b0;
        case (dig)
            2'd0:    sel_val = {1'b0, count_f};
            2'd1: begin
                sel_val = wrap_f;
                sel_sat = sat_f;
            end
            2'd2:    sel_val = {1'b0, count_s};
            default: begin
                sel_val = wrap_s;
                sel_sat = sat_s;
            end
        endcase
    end

    // Decisions are made from pcnt as seen at the edge, so the registered
    // outputs describe slot position pcnt during the following cycle.
    always_comb begin
        state_d    = state_q;
        snap_d     = snap_q;
        snap_sat_d = snap_sat_q;
        an_d       = AN_OFF;
        seg_d      = SEG_OFF;
        dp_d       = 1'b1;

        if (pcnt == 16'd0) begin
            snap_d     = sel_val;
            snap_sat_d = sel_sat;
        end

        case (state_q)
            BLANK: begin
                if (pcnt >= BLANK_LIM) begin
                    state_d = SHOW;
                end
            end
            default: begin
                if (pcnt == 16'd0 && BLANK_EN && BLANK_LIM != 16'd0) begin
                    state_d = BLANK;
                end else begin
                    state_d = SHOW;
                end
            end
        endcase

        if (state_d == SHOW) begin
            an_d  = ~(4'b0001 << dig);
            seg_d = hex2seg(snap_d);
            dp_d  = ~snap_sat_d;
        end
    end

    always_ff @(posedge clk_f) begin
        if (rst) begin
            pcnt       <= 16'd0;
            dig        <= 2'd0;
            state_q    <= RESET_IDLE;
            snap_q     <= 4'd0;
            snap_sat_q <= 1'b0;
            an         <= AN_OFF;
            seg        <= SEG_OFF;
            dp         <= 1'b1;
        end else begin
            if (pcnt == PCNT_MAX) begin
                pcnt <= 16'd0;
                dig  <= dig + 2'd1;
            end else begin
                pcnt <= pcnt + 16'd1;
            end
            state_q    <= state_d;
            snap_q     <= snap_d;
            snap_sat_q <= snap_sat_d;
            an         <= an_d;
            seg        <= seg_d;
            dp         <= dp_d;
        end
    end

endmodule

// File: tb/tb_seg7_scan.sv
// tb/tb_seg7_scan.sv - scoreboard bench for seg7_scan against a slot-arithmetic reference model
module tb_seg7_scan;

`ifdef SEG7_SCAN_BLANK_EN
    localparam int RDIV = 8;
    localparam int BCYC = 2;
    localparam bit BEN  = 1'b1;
`else
    localparam int RDIV = 4;
    localparam int BCYC = 2;
    localparam bit BEN  = 1'b0;
`endif
    localparam int SHOW_OFF = BEN ? BCYC : 0;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] count_s = 3'd0;
    logic [2:0] count_f = 3'd0;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    exp_t q[$];

    logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Reference model state: cycles since reset, wrap counts, last samples, latched digit value.
    int t, wf, ws, pf, ps, snap;

    seg7_scan #(.REFRESH_DIV(RDIV), .BLANK_CYC(BCYC)) dut (
        .clk_f   (clk),
        .rst     (rst),
        .count_s (count_s),
        .count_f (count_f),
        .an      (an),
        .seg     (seg),
        .dp      (dp)
    );

    always #5 clk = ~clk;

    function automatic int next_wrap(input int w, input int p, input int c);
        if (c == 0 && p == 7) return (w < 15) ? w + 1 : 15;
        if (c == 0 && p != 0) return 0;
        return w;
    endfunction

    task automatic model_edge(input bit r, input int cf, input int cs);
        exp_t e;
        int pos;
        int d;
        e.an  = 4'hF;
        e.seg = 7'h7F;
        e.dp  = 1'b1;
        if (r) begin
            t = 0; wf = 0; ws = 0; pf = 0; ps = 0; snap = 0;
        end else begin
            pos = t % RDIV;
            d   = (t / RDIV) % 4;
            if (pos == 0) begin
                case (d)
                    0: snap = cf;
                    1: snap = wf;
                    2: snap = cs;
                    default: snap = ws;
                endcase
            end
            if (!(BEN && pos < BCYC)) begin
                e.an  = 4'hF & ~(4'b0001 << d);
                e.seg = glyph[snap];
                e.dp  = !((d % 2 == 1) && snap == 15);
            end
            wf = next_wrap(wf, pf, cf);
            ws = next_wrap(ws, ps, cs);
            pf = cf;
            ps = cs;
            t++;
        end
        q.push_back(e);
    endtask

    task automatic step(input bit r, input int cf, input int cs);
        @(negedge clk);
        rst     = r;
        count_f = 3'(cf);
        count_s = 3'(cs);
        model_edge(r, cf, cs);
    endtask

    task automatic check_now(input string name, input logic [3:0] ea, input logic [6:0] es);
        @(posedge clk);
        #2;
        n_checks++;
        if (an === ea && seg === es) n_pass++;
        else $display("FAIL %s: an=%b seg=%h, expected an=%b seg=%h", name, an, seg, ea, es);
    endtask

    always @(posedge clk) begin
        exp_t e;
        cyc++;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            n_checks++;
            if (an === e.an && seg === e.seg && dp === e.dp) n_pass++;
            else $display("FAIL scan cycle %0d: an=%b seg=%h dp=%b, expected an=%b seg=%h dp=%b",
                          cyc, an, seg, dp, e.an, e.seg, e.dp);
        end
    end

    initial begin
        int cf, cs, r;

        // Reset, then release with count_f = 5.
        cf = 5; cs = 0;
        repeat (3) step(1, cf, cs);
        repeat (SHOW_OFF + 1) step(0, cf, cs);
        check_now("first_digit0", 4'b1110, 7'h12);
        repeat (RDIV) step(0, cf, cs);
        check_now("first_digit1", 4'b1101, 7'h40);

        // count_f 6 -> 7 -> 0 produces one fast wrap.
        cf = 6; step(0, cf, cs);
        cf = 7; step(0, cf, cs);
        cf = 0;
        repeat (5 * RDIV) step(0, cf, cs);

        // Sixteen full wraps of count_s saturate its tracker.
        for (int w = 0; w < 16; w++) begin
            for (int v = 1; v <= 8; v++) begin
                cs = v % 8;
                step(0, cf, cs);
            end
        end
        repeat (5 * RDIV) step(0, cf, cs);

        // count_s jumps 3 -> 0: upstream reset clears wrap_s.
        for (int v = 1; v <= 3; v++) begin
            cs = v;
            step(0, cf, cs);
        end
        cs = 0;
        repeat (5 * RDIV) step(0, cf, cs);

        // Reset in the middle of the digit2 slot.
        for (int k = 0; k < 8 * RDIV && !(((t / RDIV) % 4 == 2) && (t % RDIV == 1)); k++) begin
            cf = (cf + 1) % 8;
            step(0, cf, cs);
        end
        step(1, cf, cs);
        check_now("mid_slot_reset", 4'b1111, 7'h7F);
        step(0, cf, cs);
        check_now("release_after_reset", BEN ? 4'b1111 : 4'b1110, BEN ? 7'h7F : glyph[cf]);

        // Randomized counts with occasional resets.
        for (int i = 0; i < 800; i++) begin
            r = $urandom_range(0, 9);
            if (r < 6) cf = (cf + 1) % 8;
            else if (r == 8) cf = $urandom_range(0, 7);
            r = $urandom_range(0, 9);
            if (r < 7) cs = (cs + 1) % 8;
            else if (r == 8) cs = $urandom_range(0, 7);
            step($urandom_range(0, 299) == 0, cf, cs);
        end

        repeat (3) @(posedge clk);
        #3;
        n_checks++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL drain: %0d entries left, expected 0", q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/seg7_scan.md
# seg7_scan

Display-side stage that consumes the slow-domain and fast-domain event counts (`count_s`, `count_f`) produced by the event counter and drives a 4-digit common-anode seven-segment display. It tracks 7→0 wrap-arounds of each 3-bit count in saturating 4-bit wrap counters, so each count is shown with an extra high digit. It time-multiplexes the four digits at a parameterised refresh rate, all on the fast clock.

## Interface
- `REFRESH_DIV`, default 1000: `clk_f` cycles per digit slot; legal range 4..65535.
- `BLANK_CYC`, default 16: leading blank cycles per slot. Used only with `SEG7_SCAN_BLANK_EN`. Must be < `REFRESH_DIV`.
- `clk_f` in 1: single clock for the whole block.
- `rst` in 1: synchronous, active-high reset.
- `count_s` in 3: slow count from the upstream counter, sampled on `clk_f`.
- `count_f` in 3: fast count from the upstream counter.
- `an` out 4: digit anodes, active-low; bit i enables digit i.
- `seg` out 7: segments {g,f,e,d,c,b,a}, active-low.
- `dp` out 1: decimal point, active-low.

## Operation
- Digit map:
  - digit0 = `count_f` (0–7)
  - digit1 = `wrap_f` (0–F)
  - digit2 = `count_s`
  - digit3 = `wrap_s`
- Wrap tracking runs every `clk_f` cycle, one tracker per count. Each tracker holds `prev` (3b, reset 0) and `wrap` (4b, reset 0).
  - cur==0 and prev==7: `wrap` increments, saturating at 15.
  - cur==0 and prev∉{0,7}: `wrap` clears to 0; this is treated as an upstream reset.
  - Otherwise `wrap` holds. `prev` <= cur every cycle.
- Scan FSM states:
  - RESET_IDLE: the `rst` cycle only.
  - BLANK: present only with the macro.
  - SHOW.
- Prescaler `pcnt` counts 0..`REFRESH_DIV`-1 and then wraps. Digit index `dig` (2b) advances 0→1→2→3→0 on each `pcnt` wrap.
- Slot start is `pcnt`==0. At slot start the selected digit value is latched into a snapshot register and held constant for the whole slot.
- For wrap digits, the snapshot uses the registered `wrap` value before that edge's update.
- `seg` = hex decode of the snapshot. Count digits are zero-extended to 4b.
- `dp` is low only while showing digit1 or digit3 with a saturated (15) wrap counter; otherwise high.
- Only one `an` bit is ever low at a time.

## Timing
- All outputs are registered.
- Reset values:
  - `an`=4'b1111, `seg`=7'h7F, `dp`=1
  - `pcnt`=0, `dig`=0
  - `wrap_f`=`wrap_s`=0, `prev`=0
- Without the macro: on the first edge with `rst`=0, `an` becomes 4'b1110 and `seg` becomes decode(`count_f` at that edge). Each digit is then shown for exactly `REFRESH_DIV` cycles. The full frame is 4×`REFRESH_DIV` cycles.
- Wrap latency: `wrap` updates on the edge on which cur==0 is sampled. It becomes visible at the next slot start of its digit.
- `rst` asserted mid-slot: on that edge all state returns to reset values, outputs go dark, and the scan restarts at digit0.
- Simultaneous wrap on both counts: both trackers update independently on the same edge.
- Input change mid-slot: the display does not change until that digit's next slot.

## Configuration
- `SEG7_SCAN_BLANK_EN` defined:
  - Each slot begins with `BLANK_CYC` cycles in BLANK (`an`=4'b1111, `seg`=7'h7F, `dp`=1), followed by `REFRESH_DIV`-`BLANK_CYC` cycles in SHOW.
  - The snapshot is still latched at `pcnt`==0.
  - This suppresses ghosting.
- Undefined: no BLANK state; SHOW lasts the whole slot.
- Frame length is identical in both builds.

## Structure
- Package `seg7_pkg` holds:
  - `digit_idx_t` (2b)
  - `scan_state_t` enum {RESET_IDLE, BLANK, SHOW}
  - `SEG_OFF`=7'h7F, `AN_OFF`=4'hF
  - function `hex2seg` (4b → 7b active-low), with full 0–F glyph table
- Sub-module `wrap_tracker` (ports `clk_f`, `rst`, `cnt[2:0]`, `wrap[3:0]`, `sat`) is instantiated twice.
- Top level contains the prescaler, scan FSM, snapshot mux, and output registers.

## Test plan
- Reset, then release with `count_f`=5, `REFRESH_DIV`=4:
  - first edge: `an`=1110, `seg`=7'h12 (glyph 5)
  - after 4 cycles: `an`=1101, `seg`=7'h40 (glyph 0)
- Step `count_f` 6→7→0: `wrap_f`=1, and the digit1 slot shows `seg`=7'h79.
- Drive `count_s` through 16 full wraps: `wrap_s` saturates at 15, and the digit3 slot shows `seg`=7'h0E with `dp`=0.
- Step `count_s` 3→0 (upstream reset): `wrap_s` clears to 0, and the next digit3 slot shows glyph 0.
- Assert `rst` mid-slot at `dig`=2:
  - next edge: `an`=1111, `seg`=7'h7F
  - first edge after release: `an`=1110
- With `SEG7_SCAN_BLANK_EN`, `REFRESH_DIV`=8, `BLANK_CYC`=2: each slot shows `an`=1111 for 2 cycles, then the digit is active for 6 cycles.
